// File: rtl/split_pkg.sv
// split_pkg
// Shared types and constants for the split_* stream evaluators.
//   state_t     : evaluator FSM states (IDLE, COLLECT, EVAL, DONE)
//   MODE_*      : predicate selectors
//   sum_width() : accumulator width that cannot overflow for n values of max_w bits
package split_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EVAL    = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int MODE_TAUT  = 0;
  localparam int MODE_LIMIT = 1;
  localparam int MODE_SUM   = 2;

  function automatic int sum_width(input int max_w, input int n);
    return max_w + $clog2(n + 1);
  endfunction

endpackage

// File: rtl/split_acc.sv
// split_acc
// Per-frame accumulator: beat count, running sum and the "every value <= LIMIT" flag.
// Ports:
//   clk, rst_n  : clock, async active-low reset (all state to zero)
//   i_clr       : start of frame; count=0, sum=0, all_ok=1
//   i_en        : accept i_data into the frame (ignored while i_clr is high)
//   i_data      : MAX_W-bit variable value
//   o_count     : beats accepted so far
//   o_sum       : sum of accepted values
//   o_all_ok    : every accepted value was <= LIMIT
module split_acc #(
  parameter int              MAX_W = 16,
  parameter int              CNT_W = 6,
  parameter int              SUM_W = 22,
  parameter logic [MAX_W-1:0] LIMIT = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [MAX_W-1:0] i_data,
  output logic [CNT_W-1:0] o_count,
  output logic [SUM_W-1:0] o_sum,
  output logic             o_all_ok
);

  logic [CNT_W-1:0] r_count;
  logic [SUM_W-1:0] r_sum;
  logic             r_all_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_sum    <= '0;
      r_all_ok <= 1'b0;
    end else if (i_clr) begin
      r_count  <= '0;
      r_sum    <= '0;
      r_all_ok <= 1'b1;
    end else if (i_en) begin
      r_count  <= r_count + CNT_W'(1);
      r_sum    <= r_sum + SUM_W'(i_data);
      r_all_ok <= r_all_ok & (i_data <= LIMIT);
    end
  end

  assign o_count  = r_count;
  assign o_sum    = r_sum;
  assign o_all_ok = r_all_ok;

endmodule

// File: rtl/split_stream_eval.sv
// split_stream_eval
// Collects NUM_VARS variables one per beat and evaluates a MODE-selected predicate.
// Ports:
//   clk, rst_n           : clock, async active-low reset
//   start                : begin a frame (sampled in IDLE only)
//   in_valid/in_ready    : variable beat handshake; in_data value, in_last frame end marker
//   out_valid/out_ready  : result handshake
//   x                    : predicate result, err: frame length mismatch (valid with out_valid)
// Timing: the last beat taken at edge N is followed by one EVAL cycle, so the consumer
// first samples out_valid=1 at edge N+2. A frame closes on in_last or on the
// NUM_VARS-th beat, whichever comes first; extra beats are left unaccepted.
module split_stream_eval
  import split_pkg::*;
#(
  parameter int               NUM_VARS = 35,
  parameter int               MAX_W    = 16,
  parameter int               MODE     = 0,
  parameter logic [MAX_W-1:0] LIMIT    = '1,
  localparam int              SUM_W    = sum_width(MAX_W, NUM_VARS),
  parameter logic [SUM_W-1:0] TARGET   = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MAX_W-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             x,
  output logic             err
);

  localparam int               CNT_W    = $clog2(NUM_VARS + 1);
  localparam logic [CNT_W:0]   ONE_CNT  = 1;
  localparam logic [CNT_W:0]   LAST_CNT = NUM_VARS;

  generate
    if (MODE > MODE_SUM || MODE < MODE_TAUT || NUM_VARS < 1) begin : g_bad_param
      $fatal(1, "split_stream_eval: illegal MODE or NUM_VARS");
    end
  endgenerate

  state_t           r_state, w_next;
  logic             r_x, r_err, r_last;
  logic             w_xfer, w_end, w_clr;
  logic             w_x, w_err;
  logic [CNT_W-1:0] w_count;
  logic [SUM_W-1:0] w_sum;
  logic             w_all_ok;
  logic [CNT_W:0]   w_cnt_nx;

  assign w_clr    = (r_state == IDLE) & start;
  assign w_xfer   = (r_state == COLLECT) & in_valid;
  assign w_cnt_nx = {1'b0, w_count} + ONE_CNT;
  // Frame closes on the marked beat or the NUM_VARS-th beat, whichever is first.
  assign w_end    = w_xfer & (in_last | (w_cnt_nx == LAST_CNT));

  split_acc #(
    .MAX_W (MAX_W),
    .CNT_W (CNT_W),
    .SUM_W (SUM_W),
    .LIMIT (LIMIT)
  ) u_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_clr),
    .i_en     (w_xfer),
    .i_data   (in_data),
    .o_count  (w_count),
    .o_sum    (w_sum),
    .o_all_ok (w_all_ok)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start)     w_next = COLLECT;
      COLLECT: if (w_end)     w_next = EVAL;
      EVAL:                   w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default:                w_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      COLLECT: in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // The last accepted beat overwrites this, so in EVAL it holds that beat's marker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_last <= 1'b0;
    else if (w_clr)  r_last <= 1'b0;
    else if (w_xfer) r_last <= in_last;
  end

  always_comb begin
    w_err = (w_count != CNT_W'(NUM_VARS)) | ~r_last;
    if (MODE == MODE_LIMIT)    w_x = w_all_ok & ~w_err;
    else if (MODE == MODE_SUM) w_x = (w_sum == TARGET) & ~w_err;
    else                       w_x = 1'b1;
  end

  // Result registers load once in EVAL and hold through DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x   <= 1'b0;
      r_err <= 1'b0;
    end else if (r_state == EVAL) begin
      r_x   <= w_x;
      r_err <= w_err;
    end
  end

  assign x   = r_x;
  assign err = r_err;

endmodule

// File: tb/tb_split_stream_eval.sv
// tb_split_stream_eval
// Four evaluators share one stimulus stream:
//   u0 MODE0 N=4, u1 MODE1 N=4 LIMIT=7, u2 MODE2 N=4 TARGET=10, u3 MODE2 N=1 TARGET=5.
// A frame-level model predicts handshakes and results for each; directed frames add
// hand-computed literal checks, then a randomized run covers mixed traffic and resets.
module tb_split_stream_eval;

  logic        clk, rst_n, start, in_valid, in_last, out_ready;
  logic [15:0] in_data;
  logic [3:0]  ir, ov, xo, eo;

  int n_tests = 0;
  int n_fail  = 0;

  split_stream_eval #(.NUM_VARS(4), .MAX_W(16), .MODE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(ir[0]),
    .in_data(in_data), .in_last(in_last), .out_valid(ov[0]), .out_ready(out_ready),
    .x(xo[0]), .err(eo[0]));
  split_stream_eval #(.NUM_VARS(4), .MAX_W(16), .MODE(1), .LIMIT(16'd7)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(ir[1]),
    .in_data(in_data), .in_last(in_last), .out_valid(ov[1]), .out_ready(out_ready),
    .x(xo[1]), .err(eo[1]));
  split_stream_eval #(.NUM_VARS(4), .MAX_W(16), .MODE(2), .TARGET(10)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(ir[2]),
    .in_data(in_data), .in_last(in_last), .out_valid(ov[2]), .out_ready(out_ready),
    .x(xo[2]), .err(eo[2]));
  split_stream_eval #(.NUM_VARS(1), .MAX_W(16), .MODE(2), .TARGET(5)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(ir[3]),
    .in_data(in_data), .in_last(in_last), .out_valid(ov[3]), .out_ready(out_ready),
    .x(xo[3]), .err(eo[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- frame-level model ----------------
  int NV[4] = '{4, 4, 4, 1};
  int MD[4] = '{0, 1, 2, 2};
  int TG[4] = '{0, 0, 10, 5};
  int LIM   = 7;

  bit m_open[4], m_wait[4], m_res[4], m_x[4], m_err[4];
  int m_v[4][4];
  int m_n[4];

  function automatic void m_reset();
    for (int k = 0; k < 4; k++) begin
      m_open[k] = 0; m_wait[k] = 0; m_res[k] = 0; m_x[k] = 0; m_err[k] = 0; m_n[k] = 0;
    end
  endfunction

  function automatic void m_eval(int k, bit last);
    int s = 0;
    bit ok = 1;
    for (int i = 0; i < m_n[k]; i++) begin
      s += m_v[k][i];
      if (m_v[k][i] > LIM) ok = 0;
    end
    m_err[k] = (m_n[k] != NV[k]) || !last;
    if (MD[k] == 0)      m_x[k] = 1;
    else if (MD[k] == 1) m_x[k] = ok && !m_err[k];
    else                 m_x[k] = (s == TG[k]) && !m_err[k];
  endfunction

  // One clock edge of frame progress per instance.
  function automatic void m_step();
    for (int k = 0; k < 4; k++) begin
      if (m_res[k]) begin
        if (out_ready) m_res[k] = 0;
      end else if (m_wait[k]) begin
        m_wait[k] = 0;
        m_res[k]  = 1;
      end else if (m_open[k]) begin
        if (in_valid) begin
          m_v[k][m_n[k]] = int'(in_data);
          m_n[k]++;
          if (in_last || m_n[k] == NV[k]) begin
            m_open[k] = 0;
            m_wait[k] = 1;
            m_eval(k, in_last);
          end
        end
      end else if (start) begin
        m_open[k] = 1;
        m_n[k]    = 0;
      end
    end
  endfunction

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else        m_step();
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("in_ready[u%0d]", k), int'(ir[k]), int'(m_open[k]));
        chk($sformatf("out_valid[u%0d]", k), int'(ov[k]), int'(m_res[k]));
        if (!rst_n) begin
          chk($sformatf("rst_x[u%0d]", k), int'(xo[k]), 0);
          chk($sformatf("rst_err[u%0d]", k), int'(eo[k]), 0);
        end else if (m_res[k]) begin
          chk($sformatf("x[u%0d]", k), int'(xo[k]), int'(m_x[k]));
          chk($sformatf("err[u%0d]", k), int'(eo[k]), int'(m_err[k]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit s, input bit v, input int d, input bit l, input bit r);
    start = s; in_valid = v; in_data = 16'(d); in_last = l; out_ready = r;
    @(posedge clk); #1;
  endtask

  task automatic send(input int d0, input int d1, input int d2, input int d3,
                      input int lp, input int nb);
    int d[4];
    d = '{d0, d1, d2, d3};
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < nb; i++) cyc(0, 1, d[i], (i == lp), 0);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!ov[0] && n < 20) begin
      cyc(0, 0, 0, 0, 0);
      n++;
    end
    if (!ov[0]) begin
      n_tests++; n_fail++;
      $display("FAIL %s: out_valid timeout, got 0 expected 1", nm);
    end
  endtask

  task automatic consume();
    cyc(0, 0, 0, 0, 1);
    chk("drop_after_xfer", int'(ov[0]), 0);
    cyc(0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 0; in_valid = 0; in_data = '0; in_last = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", int'(ir[0]), 0);
    chk("reset_out_valid", int'(ov[0]), 0);
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0);

    // 1: MODE0, 4 beats, last on 4th; latency and N=1 framing
    send(1, 2, 3, 4, 3, 4);
    chk("t1_eval_cycle", int'(ov[0]), 0);
    cyc(0, 0, 0, 0, 0);
    chk("t1_latency", int'(ov[0]), 1);
    chk("t1_x", int'(xo[0]), 1);
    chk("t1_err", int'(eo[0]), 0);
    chk("t1_n1_err", int'(eo[3]), 1);
    chk("t1_n1_x", int'(xo[3]), 0);
    consume();

    // 2: MODE2 sum == 10
    send(2, 3, 5, 0, 3, 4);
    wait_done("t2a");
    chk("t2a_x", int'(xo[2]), 1);
    chk("t2a_err", int'(eo[2]), 0);
    consume();
    send(2, 3, 6, 0, 3, 4);
    wait_done("t2b");
    chk("t2b_x", int'(xo[2]), 0);
    chk("t2b_err", int'(eo[2]), 0);
    consume();

    // 3: MODE1 LIMIT=7
    send(7, 0, 8, 1, 3, 4);
    wait_done("t3a");
    chk("t3a_x", int'(xo[1]), 0);
    send_check_dummy();
    consume();
    send(7, 7, 7, 7, 3, 4);
    wait_done("t3b");
    chk("t3b_x", int'(xo[1]), 1);
    consume();

    // 4a: early last on 2nd beat; sum hits 10 but frame is short
    send(5, 5, 0, 0, 1, 2);
    wait_done("t4a");
    chk("t4a_err", int'(eo[2]), 1);
    chk("t4a_x", int'(xo[2]), 0);
    chk("t4a_taut_x", int'(xo[0]), 1);
    consume();

    // 4b: no last on 4th beat; 5th beat left unaccepted
    send(1, 2, 3, 4, -1, 4);
    chk("t4b_held", int'(ir[0]), 0);
    cyc(0, 1, 9, 1, 0);
    chk("t4b_held2", int'(ir[0]), 0);
    wait_done("t4b");
    chk("t4b_err", int'(eo[0]), 1);
    consume();

    // N=1 with last on first beat: value 5 matches TARGET
    send(5, 1, 1, 1, 0, 1);
    wait_done("t4c");
    chk("t4c_n1_x", int'(xo[3]), 1);
    chk("t4c_n1_err", int'(eo[3]), 0);
    consume();

    // 5: hold in DONE, start pulse ignored
    send(2, 3, 5, 0, 3, 4);
    wait_done("t5");
    for (int i = 0; i < 5; i++) begin
      cyc(i == 2, 0, 0, 0, 0);
      chk("t5_hold_valid", int'(ov[0]), 1);
      chk("t5_hold_x", int'(xo[2]), 1);
      chk("t5_hold_err", int'(eo[2]), 0);
    end
    consume();
    chk("t5_no_restart", int'(ir[0]), 0);

    // 6: reset mid-frame, then a fresh frame
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 3, 0, 0);
    cyc(0, 1, 4, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("t6_abort_ready", int'(ir[0]), 0);
    chk("t6_abort_valid", int'(ov[0]), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0);
    send(2, 3, 5, 0, 3, 4);
    wait_done("t6");
    chk("t6_x", int'(xo[2]), 1);
    chk("t6_err", int'(eo[2]), 0);
    consume();

    // Randomized traffic, checked every cycle against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
      else                             rst_n = 1'b1;
      cyc($urandom_range(0, 4) == 0,
          $urandom_range(0, 9) < 6,
          ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 65535)),
          $urandom_range(0, 3) == 0,
          $urandom_range(0, 1) == 1);
    end
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Frame 7,0,8,1 is full-length with last, so err must stay low despite x=0.
  task automatic send_check_dummy();
    chk("t3a_err", int'(eo[1]), 0);
  endtask

endmodule
